pwm_dac_stage: RTL and testbench
================================

Name: pwm_dac_stage

Overview:
Output stage downstream of the 8-bit waveform generators. It accepts samples over a valid/ready handshake and holds one pending sample. At each PWM period boundary it loads the pending sample as the new duty value. It drives a single-bit PWM line to the board-level RC filter, so the result is a low-cost DAC.

Parameters:
WIDTH, 8, sample and duty width in bits; PWM period is 2^WIDTH-1 counts.
PRESCALE, 1, clocks per PWM count; legal range 1..65535.

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
sample_in  in  WIDTH  unsigned sample from upstream waveform generator
sample_valid  in  1  sample_in is valid this cycle
sample_ready  out  1  stage can accept a sample this cycle
enable  in  1  1 = PWM running, 0 = output parked low
clear_underrun  in  1  one-cycle pulse that clears the underrun flag
pwm_out  out  1  registered PWM output
period_start  out  1  one-cycle pulse at the first count of each PWM period
underrun  out  1  sticky flag: a period boundary found no pending sample

Behaviour:
- Reset (reset_n low, asynchronous) clears all state:
  - pending_valid=0, duty=0, cnt=0, prescale counter=0.
  - pwm_out=0, period_start=0, underrun=0.
  - sample_ready=1 immediately, because it is combinational from pending_valid.
- Asserting reset mid-period abandons the current period and drops any pending sample.
- Handshake:
  - sample_ready = !pending_valid.
  - Accept occurs on sample_valid && sample_ready; sample_in is then written to the pending register.
  - The upstream block must hold sample_in stable while valid && !ready.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1.
  - tick=1 when the prescaler is at PRESCALE-1.
  - PRESCALE=1 gives tick=1 every cycle.
- PWM counter cnt:
  - Range 0..2^WIDTH-2 (255 steps when WIDTH=8).
  - Advances on tick; wraps from 2^WIDTH-2 to 0.
  - The boundary is the tick at which cnt wraps to 0.
- Boundary actions (enable=1):
  - Pending sample present: duty <= pending; pending_valid <= 0.
  - No pending sample, but an accept occurs in the same cycle: bypass, so duty <= sample_in; pending stays empty; no underrun.
  - Neither: duty is held and underrun <= 1.
- Output:
  - pwm_out <= enable && (cnt < duty), registered, so 1 cycle latency from cnt.
  - duty=0 gives constant 0.
  - duty=2^WIDTH-1 gives constant 1 (100%).
  - Compare is unsigned, WIDTH+0 bits, with no extension needed.
- period_start: registered pulse, high for exactly one clock in the cycle after the boundary tick.
- Disabled (enable=0):
  - cnt and prescaler are forced to 0; pwm_out=0; period_start=0; underrun does not set.
  - A pending sample transfers to duty on the next clock, so the stage keeps draining.
- Re-enable: the period begins at cnt=0 using the current duty. The first boundary occurs after a full period.
- underrun:
  - Sticky; cleared by clear_underrun.
  - If a set and a clear happen in the same cycle, set wins.

Decomposition:
- Shared package pwm_dac_pkg holds:
  - default WIDTH and PRESCALE constants;
  - function period_max(width) returning 2^width-2.
- One sub-module, tick_prescaler:
  - Parameter PRESCALE; ports clk, reset_n, enable, tick.
  - Reusable by other codebase blocks that need a rate divider.
- Counter, pending register, duty register and flag logic live in pwm_dac_stage.

Test Plan:
- Reset check: reset_n low -> pwm_out=0, sample_ready=1, underrun=0, period_start=0. Release, enable=1, no samples, 255 cycles -> pwm_out=0 throughout.
- Duty sweep (PRESCALE=1): feed 64 before boundary -> next period has exactly 64 high clocks out of 255. Repeat with 0 -> 0 high; 255 -> 255 high; 128 -> 128 high.
- Backpressure: send 10 then 20 back-to-back mid-period -> 10 accepted; sample_ready=0 until the boundary; 20 accepted the cycle after the boundary; the following periods use duty 10 then 20.
- Underrun: one sample of 50, then none -> at the second boundary underrun=1 and duty stays 50. Pulse clear_underrun -> 0. Assert clear at a cycle with a fresh underrun -> stays 1.
- Bypass and disable:
  - Pending empty, assert valid with value 99 exactly on the boundary cycle -> duty=99 that period, no underrun.
  - Drop enable mid-period -> pwm_out=0 next cycle, cnt=0.
- Prescaler and reset mid-op:
  - PRESCALE=4, duty=128 -> period_start pulses every 1020 clocks, 512 high clocks per period.
  - Pull reset_n low at cnt=100 -> pwm_out=0 asynchronously and the pending sample is lost.

Source files
------------

// File: rtl/pwm_dac_pkg.sv
// ---------------------------------------------------------------------------
// pwm_dac_pkg
// Shared constants and helpers for the PWM DAC output stage and its
// rate-divider sub-block.
//   DEFAULT_WIDTH    : sample / duty width in bits
//   DEFAULT_PRESCALE : clocks per PWM count
//   period_max()     : last PWM counter value (2^width - 2), so a period
//                      spans 2^width - 1 counts and full-scale duty is 100%
// ---------------------------------------------------------------------------
package pwm_dac_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_PRESCALE = 1;

    function automatic int unsigned period_max(input int unsigned width);
        return (32'd1 << width) - 32'd2;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Rate divider: emits a one-cycle tick every PRESCALE clocks while enabled.
// The count is held at zero while disabled, so the first tick after enabling
// arrives PRESCALE clocks later (immediately for PRESCALE = 1).
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   enable  : 1 = counting, 0 = counter parked at zero
//   tick    : high during the last clock of each PRESCALE-clock interval
// ---------------------------------------------------------------------------
module tick_prescaler
    import pwm_dac_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    // PRESCALE = 1 still needs a 1-bit register so the port shape is uniform
    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        presc_d = presc_q;
        if (!enable || (presc_q == LAST)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = enable && (presc_q == LAST);

endmodule

// File: rtl/pwm_dac_stage.sv
// ---------------------------------------------------------------------------
// pwm_dac_stage
// Low-cost DAC output stage: takes samples over valid/ready, holds one
// pending sample, and loads it as the PWM duty at each period boundary.
// The single-bit pwm_out feeds an external RC filter.
// Ports:
//   clk            : system clock, rising edge
//   reset_n        : asynchronous active-low reset
//   sample_in      : unsigned sample from the waveform generator
//   sample_valid   : sample_in valid this cycle
//   sample_ready   : stage can accept a sample (no sample pending)
//   enable         : 1 = PWM running, 0 = output parked low
//   clear_underrun : pulse clearing the sticky underrun flag
//   pwm_out        : registered PWM line
//   period_start   : one-cycle pulse on the first count of each period
//   underrun       : sticky, a boundary found no sample to load
// ---------------------------------------------------------------------------
module pwm_dac_stage
    import pwm_dac_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             enable,
    input  logic             clear_underrun,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(period_max(WIDTH));

    logic             tick;
    logic             accept;
    logic             boundary;

    logic [WIDTH-1:0] pending_q,       pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic [WIDTH-1:0] duty_q,          duty_d;
    logic [WIDTH-1:0] cnt_q,           cnt_d;
    logic             pwm_q,           pwm_d;
    logic             period_start_q,  period_start_d;
    logic             underrun_q,      underrun_d;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    assign sample_ready = !pending_valid_q;
    assign accept       = sample_valid && !pending_valid_q;
    // tick is only ever high while enabled, so boundary implies enable
    assign boundary     = tick && (cnt_q == CNT_MAX);

    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        duty_d          = duty_q;
        cnt_d           = cnt_q;
        underrun_d      = underrun_q;

        if (!enable) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
        end

        if (accept) begin
            pending_d       = sample_in;
            pending_valid_d = 1'b1;
        end

        if (clear_underrun) begin
            underrun_d = 1'b0;
        end

        if (boundary) begin
            if (pending_valid_q) begin
                duty_d          = pending_q;
                pending_valid_d = 1'b0;
            end else if (accept) begin
                // Sample arriving exactly on the boundary skips the pending slot
                duty_d          = sample_in;
                pending_valid_d = 1'b0;
            end else begin
                // Placed after the clear so a coincident set wins
                underrun_d = 1'b1;
            end
        end else if (!enable && pending_valid_q) begin
            // Keep draining while parked so upstream never stalls
            duty_d          = pending_q;
            pending_valid_d = 1'b0;
        end

        pwm_d          = enable && (cnt_q < duty_q);
        period_start_d = boundary;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            duty_q          <= '0;
            cnt_q           <= '0;
            pwm_q           <= 1'b0;
            period_start_q  <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            duty_q          <= duty_d;
            cnt_q           <= cnt_d;
            pwm_q           <= pwm_d;
            period_start_q  <= period_start_d;
            underrun_q      <= underrun_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_dac_stage.sv
module tb_pwm_dac_stage;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       enable;
    logic       clear_underrun;
    logic       pwm_out;
    logic       period_start;
    logic       underrun;

    logic [7:0] s4_in;
    logic       s4_valid;
    logic       s4_ready;
    logic       s4_en;
    logic       s4_clr;
    logic       s4_pwm;
    logic       s4_ps;
    logic       s4_ur;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    pwm_dac_stage #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .enable         (enable),
        .clear_underrun (clear_underrun),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .underrun       (underrun)
    );

    pwm_dac_stage #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_in      (s4_in),
        .sample_valid   (s4_valid),
        .sample_ready   (s4_ready),
        .enable         (s4_en),
        .clear_underrun (s4_clr),
        .pwm_out        (s4_pwm),
        .period_start   (s4_ps),
        .underrun       (s4_ur)
    );

    task automatic send(input logic [7:0] v);
        logic acc;
        acc = 1'b0;
        sample_in    = v;
        sample_valid = 1'b1;
        for (int n = 0; n < 3000 && !acc; n++) begin
            acc = sample_ready;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_accept: sample %0d accepted=%b required 1", v, acc);
        end
    endtask

    task automatic send4(input logic [7:0] v);
        logic acc;
        acc = 1'b0;
        s4_in    = v;
        s4_valid = 1'b1;
        for (int n = 0; n < 3000 && !acc; n++) begin
            acc = s4_ready;
            @(negedge clk);
        end
        s4_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send4_accept: sample %0d accepted=%b required 1", v, acc);
        end
    endtask

    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 3000);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_ps_timeout: period_start=%b required 1", period_start);
        end
    endtask

    task automatic wait_ps4();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s4_ps && n < 5000);
        checks++;
        if (s4_ps !== 1'b1) begin
            errors++;
            $display("FAIL wait_ps4_timeout: period_start=%b required 1", s4_ps);
        end
    endtask

    // Called on the negedge of a period_start cycle; counts high clocks of that period
    task automatic measure();
        int hc;
        int exp;
        hc = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (i == 0) sample_valid = 1'b0;
            if (pwm_out === 1'b1) hc++;
        end
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL period_length: period_start=%b after 255 clocks required 1", period_start);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d high clocks, no expectation queued", hc);
        end else begin
            exp = exp_q.pop_front();
            if (hc !== exp) begin
                errors++;
                $display("FAIL duty_high_count: got %0d high clocks required %0d", hc, exp);
            end
        end
    endtask

    task automatic measure4();
        int hc;
        int psn;
        int exp;
        hc  = 0;
        psn = 0;
        for (int i = 0; i < 1020; i++) begin
            @(negedge clk);
            if (s4_pwm === 1'b1) hc++;
            if (s4_ps === 1'b1) psn++;
        end
        checks++;
        if (s4_ps !== 1'b1 || psn != 1) begin
            errors++;
            $display("FAIL presc_period: end pulse=%b pulses=%0d required 1 and 1", s4_ps, psn);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty4: got %0d high clocks, no expectation queued", hc);
        end else begin
            exp = exp_q.pop_front();
            if (hc !== exp) begin
                errors++;
                $display("FAIL presc_high_count: got %0d high clocks required %0d", hc, exp);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        reset_n        = 1'b0;
        enable         = 1'b0;
        sample_in      = '0;
        sample_valid   = 1'b0;
        clear_underrun = 1'b0;
        s4_in    = '0;
        s4_valid = 1'b0;
        s4_en    = 1'b0;
        s4_clr   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b required 0", pwm_out); end
        checks++;
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", sample_ready); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        checks++;
        if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b required 0", period_start); end
        checks++;
        if (s4_ready !== 1'b1) begin errors++; $display("FAIL reset_ready4: got %b required 1", s4_ready); end
        reset_n = 1'b1;
        enable  = 1'b1;
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_pwm_low: high clocks %0d required 0", bad); end
    endtask

    task automatic test_duty_sweep();
        int vals[4] = '{64, 0, 255, 128};
        foreach (vals[k]) begin
            exp_q.push_back(vals[k]);
            send(8'(vals[k]));
            wait_ps();
            measure();
        end
    endtask

    task automatic test_back_to_back();
        int n;
        wait_ps();
        repeat (50) @(negedge clk);
        exp_q.push_back(10);
        exp_q.push_back(20);
        sample_in    = 8'd10;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_in = 8'd20;
        checks++;
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b required 0", sample_ready); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_ready && n < 600);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_at_boundary: period_start=%b when ready rose, required 1", period_start);
        end
        measure();
        measure();
    endtask

    task automatic test_underrun();
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear0: got %b required 0", underrun); end
        send(8'd50);
        wait_ps();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_first_boundary: got %b required 0", underrun); end
        wait_ps();
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur_second_boundary: got %b required 1", underrun); end
        exp_q.push_back(50);
        measure();
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b required 0", underrun); end
        repeat (253) @(negedge clk);
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b1 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL ur_set_wins: underrun=%b ps=%b required 1 1", underrun, period_start);
        end
    endtask

    task automatic test_bypass();
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL byp_clear: got %b required 0", underrun); end
        repeat (253) @(negedge clk);
        sample_in    = 8'd99;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        checks++;
        if (period_start !== 1'b1) begin errors++; $display("FAIL byp_ps: got %b required 1", period_start); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL byp_underrun: got %b required 0", underrun); end
        checks++;
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %b required 1", sample_ready); end
        exp_q.push_back(99);
        measure();
    endtask

    task automatic test_disable();
        repeat (20) @(negedge clk);
        checks++;
        if (pwm_out !== 1'b1) begin errors++; $display("FAIL dis_pre_high: got %b required 1", pwm_out); end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL dis_pwm_low: got %b required 0", pwm_out); end
        send(8'd30);
        @(negedge clk);
        checks++;
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL dis_drain: ready=%b required 1", sample_ready); end
        checks++;
        if (period_start !== 1'b0 || pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL dis_quiet: ps=%b pwm=%b required 0 0", period_start, pwm_out);
        end
        enable = 1'b1;
        exp_q.push_back(30);
        measure();
    endtask

    task automatic test_prescale_reset();
        send4(8'd128);
        @(negedge clk);
        s4_en = 1'b1;
        wait_ps4();
        exp_q.push_back(512);
        measure4();
        s4_in    = 8'd77;
        s4_valid = 1'b1;
        @(negedge clk);
        s4_valid = 1'b0;
        checks++;
        if (s4_ready !== 1'b0) begin errors++; $display("FAIL presc_pending: ready=%b required 0", s4_ready); end
        repeat (399) @(negedge clk);
        checks++;
        if (s4_pwm !== 1'b1) begin errors++; $display("FAIL presc_mid_high: got %b required 1", s4_pwm); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (s4_pwm !== 1'b0) begin errors++; $display("FAIL async_reset_pwm: got %b required 0", s4_pwm); end
        checks++;
        if (s4_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b required 1", s4_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        wait_ps4();
        exp_q.push_back(0);
        measure4();
    endtask

    initial begin
        test_reset();
        test_duty_sweep();
        test_back_to_back();
        test_underrun();
        test_bypass();
        test_disable();
        test_prescale_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
